// File: rtl/inst_fetch_pkg.sv
// Shared processor definitions used by the fetch stage and the pipeline top.
// Contents: bubble encoding, major opcode constants and the fetch-state enum.
package inst_fetch_pkg;

   // sll $0,$0,0 -- a true NOP, so a bubble decodes like any other instruction
   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register with stall (hold) and flush (bubble) control.
// Flush has priority over stall.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_stall           hold all fields
//   i_flush           load a bubble (NOP, pc4 = 0, valid = 0)
//   i_inst, i_pc4     fetched word and its PC+4
//   o_inst, o_pc4     registered instruction / PC+4
//   o_valid           register holds a real instruction
module if_id_reg
   import inst_fetch_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_inst;
   logic [31:0] r_pc4;
   logic        r_valid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_inst  <= INST_NOP;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_inst  <= INST_NOP;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (!i_stall) begin
         r_inst  <= i_inst;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_inst  = r_inst;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// address and loads IF/ID. Redirects (branch from EX, jump from ID) override
// a stall. A misaligned or out-of-range PC halts the stage until reset.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   o_imem_addr / i_imem_data    instruction memory read port (combinational)
//   i_stall, i_flush             hazard controls from later stages
//   i_branch_taken/_target       EX redirect
//   i_jump, i_jump_index         ID redirect (J-type)
//   o_pc                         current PC
//   o_if_id_inst/_pc4/_valid     IF/ID register contents
//   o_halted                     sticky address fault
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 256
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_data,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_jump,
   input  logic [25:0] i_jump_index,
   output logic [31:0] o_pc,
   output logic [31:0] o_if_id_inst,
   output logic [31:0] o_if_id_pc4,
   output logic        o_if_id_valid,
   output logic        o_halted
);

   localparam logic [31:0] PC_LAST = 32'(IMEM_BYTES - 4);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_jump_target;
   logic         w_fault;
   logic         w_if_stall;
   logic         w_if_flush;

   assign w_pc_plus4    = r_pc + 32'd4;
   assign w_jump_target = {o_if_id_pc4[31:28], i_jump_index, 2'b00};
   assign w_fault       = (r_pc[1:0] != 2'b00) || (r_pc > PC_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= FS_RUN;
         r_pc    <= PC_RESET;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   // Default is "hold everything", which is exactly the HALT behaviour.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_if_stall   = 1'b1;
      w_if_flush   = 1'b0;
      case (r_state)
         FS_RUN: begin
            if (w_fault) begin
               // faulting word must never reach IF/ID as valid
               w_state_next = FS_HALT;
               w_if_flush   = 1'b1;
               w_if_stall   = 1'b0;
            end else begin
               w_if_flush = i_branch_taken | i_jump | i_flush;
               w_if_stall = i_stall;
               if (i_branch_taken)
                  w_pc_next = i_branch_target;
               else if (i_jump)
                  w_pc_next = w_jump_target;
               else if (!i_stall)
                  w_pc_next = w_pc_plus4;
            end
         end
         FS_HALT: begin
            w_state_next = FS_HALT;
         end
         default: begin
            w_state_next = FS_HALT;
         end
      endcase
   end

   if_id_reg u_if_id (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_stall (w_if_stall),
      .i_flush (w_if_flush),
      .i_inst  (i_imem_data),
      .i_pc4   (w_pc_plus4),
      .o_inst  (o_if_id_inst),
      .o_pc4   (o_if_id_pc4),
      .o_valid (o_if_id_valid)
   );

   assign o_imem_addr = r_pc;
   assign o_pc        = r_pc;
   assign o_halted    = (r_state == FS_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;

   logic [31:0] mem [0:63];
   int          errors = 0;
   int          checks = 0;

   inst_fetch #(.PC_RESET(32'h0), .IMEM_BYTES(256)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .o_imem_addr     (imem_addr),
      .i_imem_data     (imem_data),
      .i_stall         (stall),
      .i_flush         (flush),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_jump          (jump),
      .i_jump_index    (jump_index),
      .o_pc            (pc),
      .o_if_id_inst    (if_id_inst),
      .o_if_id_pc4     (if_id_pc4),
      .o_if_id_valid   (if_id_valid),
      .o_halted        (halted)
   );

   assign imem_data = mem[imem_addr[7:2]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_if(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input logic [31:0] e_pc4,
                           input logic e_valid, input logic e_halted);
      check({tag, ".pc"},     pc,                 e_pc);
      check({tag, ".addr"},   imem_addr,          e_pc);
      check({tag, ".inst"},   if_id_inst,         e_inst);
      check({tag, ".pc4"},    if_id_pc4,          e_pc4);
      check({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, e_valid});
      check({tag, ".halted"}, {31'd0, halted},      {31'd0, e_halted});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush = 0; branch_taken = 0; branch_target = 32'h0;
      jump = 0; jump_index = 26'h0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
      mem[0] = 32'h8FE1_0001;
      mem[1] = 32'h8FE2_0002;
      mem[2] = 32'h8FE3_0003;
      mem[3] = 32'h8FE4_0004;
      mem[4] = 32'h8FE5_0005;
      mem[5] = 32'h8FE6_0006;
      mem[6] = 32'h8FE7_0007;
      mem[7] = 32'hAFE3_0003;

      idle();
      rst = 1'b1;
      #2;
      check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;

      // sequential fetch
      step(); check_if("seq0", 32'd4,  32'h8FE1_0001, 32'd4,  1'b1, 1'b0);
      step(); check_if("seq1", 32'd8,  32'h8FE2_0002, 32'd8,  1'b1, 1'b0);
      step(); check_if("seq2", 32'd12, 32'h8FE3_0003, 32'd12, 1'b1, 1'b0);

      // two-cycle stall at pc = 12
      stall = 1;
      step(); check_if("stall0", 32'd12, 32'h8FE3_0003, 32'd12, 1'b1, 1'b0);
      step(); check_if("stall1", 32'd12, 32'h8FE3_0003, 32'd12, 1'b1, 1'b0);
      stall = 0;
      step(); check_if("resume", 32'd16, 32'h8FE4_0004, 32'd16, 1'b1, 1'b0);
      step(); check_if("seq4",   32'd20, 32'h8FE5_0005, 32'd20, 1'b1, 1'b0);
      step(); check_if("seq5",   32'd24, 32'h8FE6_0006, 32'd24, 1'b1, 1'b0);
      step(); check_if("seq6",   32'd28, 32'h8FE7_0007, 32'd28, 1'b1, 1'b0);

      // jump index 3 with if_id_pc4 = 28 -> target 12
      jump = 1; jump_index = 26'd3;
      step(); check_if("jmp_bub", 32'd12, 32'h0, 32'h0, 1'b0, 1'b0);
      idle();
      step(); check_if("jmp_tgt", 32'd16, 32'h8FE4_0004, 32'd16, 1'b1, 1'b0);

      // branch beats jump and stall in the same cycle
      branch_taken = 1; branch_target = 32'd28; stall = 1; jump = 1; jump_index = 26'd3;
      step(); check_if("br_bub", 32'd28, 32'h0, 32'h0, 1'b0, 1'b0);
      idle();
      step(); check_if("br_tgt", 32'd32, 32'hAFE3_0003, 32'd32, 1'b1, 1'b0);

      // plain flush bubbles IF/ID while pc keeps advancing
      flush = 1;
      step(); check_if("flush", 32'd36, 32'h0, 32'h0, 1'b0, 1'b0);
      idle();

      // misaligned, out-of-range branch target -> halt
      branch_taken = 1; branch_target = 32'h102;
      step(); check_if("bad_br", 32'h102, 32'h0, 32'h0, 1'b0, 1'b0);
      idle();
      step(); check_if("halt", 32'h102, 32'h0, 32'h0, 1'b0, 1'b1);

      // stimulus ignored while halted
      branch_taken = 1; branch_target = 32'h0; jump = 1; jump_index = 26'd1; flush = 1;
      step(); check_if("halt_ign0", 32'h102, 32'h0, 32'h0, 1'b0, 1'b1);
      idle();
      step(); check_if("halt_ign1", 32'h102, 32'h0, 32'h0, 1'b0, 1'b1);

      // asynchronous reset mid-cycle while halted
      #2;
      rst = 1'b1;
      #1;
      check_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      step(); check_if("restart", 32'd4, 32'h8FE1_0001, 32'd4, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
